icap_spartan6_model: RTL and testbench

Cycle-level behavioural model of the Spartan-6 Internal Configuration Access Port (ICAP). It accepts 16-bit configuration words and tracks the sync word. It decodes Type 1 and Type 2 packet headers, keeps a small configuration register file, and returns register readback data (including IDCODE) on O. It is used in simulation in place of the device primitive, so that designs which issue ICAP command sequences, such as IDCODE readback, can be exercised.

---
 rtl/icap_spartan6_model_if.sv | 11 +
 rtl/icap_spartan6_model.sv | 185 ++++++++++++++++++
 tb/tb_icap_spartan6_model.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icap_spartan6_model_if.sv
// ICAP port bundle: enable, direction and data toward the model, readback back out.
interface icap_spartan6_model_if;
  logic        CE;
  logic        WRITE;
  logic [15:0] I;
  logic [15:0] O;
  logic        BUSY;

  modport master (output CE, output WRITE, output I, input O, input BUSY);
  modport slave  (input CE, input WRITE, input I, output O, output BUSY);
endinterface

// File: rtl/icap_spartan6_model.sv
// Cycle-level model of the Spartan-6 ICAP: sync detection, Type 1/Type 2 packet
// decode, a 32 x 16 register file and registered readback (including IDCODE).
module icap_spartan6_model #(
  parameter logic [31:0] IDCODE = 32'h24001093
) (
  input  logic                  CLK,
  input  logic                  RST,
  icap_spartan6_model_if.slave  icap
);

  typedef enum logic {UNSYNC, SYNC} sync_state_e;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  // Device pins carry each byte bit-reversed relative to the logical word.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  sync_state_e state_q, state_d;
  logic        aa99_seen_q, aa99_seen_d;
  logic [1:0]  t2_phase_q, t2_phase_d;
  logic [15:0] t2_msw_q, t2_msw_d;
  logic [1:0]  last_op_q, last_op_d;
  logic [5:0]  last_addr_q, last_addr_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic [5:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_pending_q, rd_pending_d;
  logic [31:0] rd_idx_q, rd_idx_d;
  logic        latency_q, latency_d;
  logic [15:0] o_q, o_d;
  logic        busy_q, busy_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];

  logic [15:0] word;
  logic [15:0] rd_data;
  logic [31:0] t2_count;

  assign word     = {rev8(icap.I[15:8]), rev8(icap.I[7:0])};
  assign t2_count = {t2_msw_q, word};
  assign icap.O   = {rev8(o_q[15:8]), rev8(o_q[7:0])};
  assign icap.BUSY = busy_q;

  // Readback value for the current read address and word index.
  always_comb begin
    rd_data = 16'h0000;
    if (rd_addr_q == 6'h0E) begin
      if (rd_idx_q == 32'd0)      rd_data = IDCODE[31:16];
      else if (rd_idx_q == 32'd1) rd_data = IDCODE[15:0];
    end else if (rd_addr_q != 6'h04 && !rd_addr_q[5]) begin
      rd_data = regs_q[rd_addr_q[4:0]];
    end
  end

  // Next-state logic: sync search, packet decode, data phase and read cycles.
  always_comb begin
    state_d      = state_q;
    aa99_seen_d  = aa99_seen_q;
    t2_phase_d   = t2_phase_q;
    t2_msw_d     = t2_msw_q;
    last_op_d    = last_op_q;
    last_addr_d  = last_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_count_d   = wr_count_q;
    rd_addr_d    = rd_addr_q;
    rd_pending_d = rd_pending_q;
    rd_idx_d     = rd_idx_q;
    latency_d    = latency_q;
    o_d          = o_q;
    busy_d       = busy_q;
    regs_d       = regs_q;

    if (!icap.CE && !icap.WRITE) begin
      if (state_q == UNSYNC) begin
        if (word == 16'hAA99) begin
          aa99_seen_d = 1'b1;
        end else if (aa99_seen_q && word == 16'h5566) begin
          state_d     = SYNC;
          aa99_seen_d = 1'b0;
        end else begin
          aa99_seen_d = 1'b0;
        end
      end else if (t2_phase_q == 2'd1) begin
        t2_msw_d   = word;
        t2_phase_d = 2'd2;
      end else if (t2_phase_q == 2'd2) begin
        t2_phase_d = 2'd0;
        if (last_op_q == OP_WRITE) begin
          wr_addr_d  = last_addr_q;
          wr_count_d = t2_count;
        end else if (last_op_q == OP_READ) begin
          rd_addr_d    = last_addr_q;
          rd_pending_d = t2_count;
          rd_idx_d     = 32'd0;
          latency_d    = 1'b1;
        end
      end else if (wr_count_q != 32'd0) begin
        wr_count_d = wr_count_q - 32'd1;
        if (!wr_addr_q[5] && wr_addr_q != 6'h03 && wr_addr_q != 6'h0E)
          regs_d[wr_addr_q[4:0]] = word;
        if (wr_addr_q == 6'h05 && word == 16'h000D) begin
          state_d      = UNSYNC;
          wr_count_d   = 32'd0;
          rd_pending_d = 32'd0;
          latency_d    = 1'b0;
        end
      end else begin
        case (word[15:13])
          3'b001: begin
            if (word[12:11] == OP_WRITE) begin
              last_op_d   = OP_WRITE;
              last_addr_d = word[10:5];
              wr_addr_d   = word[10:5];
              wr_count_d  = {27'd0, word[4:0]};
            end else if (word[12:11] == OP_READ) begin
              last_op_d    = OP_READ;
              last_addr_d  = word[10:5];
              rd_addr_d    = word[10:5];
              rd_pending_d = {27'd0, word[4:0]};
              rd_idx_d     = 32'd0;
              latency_d    = 1'b1;
            end
          end
          3'b010:  t2_phase_d = 2'd1;
          default: ;
        endcase
      end
    end else if (!icap.CE && icap.WRITE) begin
      if (state_q == SYNC && latency_q) begin
        busy_d    = 1'b1;
        latency_d = 1'b0;
      end else if (state_q == SYNC && rd_pending_q != 32'd0) begin
        o_d          = rd_data;
        busy_d       = 1'b0;
        rd_pending_d = rd_pending_q - 32'd1;
        rd_idx_d     = rd_idx_q + 32'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers; reset returns everything, including the register file, to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= UNSYNC;
      aa99_seen_q  <= 1'b0;
      t2_phase_q   <= 2'd0;
      t2_msw_q     <= 16'h0000;
      last_op_q    <= 2'b00;
      last_addr_q  <= 6'd0;
      wr_addr_q    <= 6'd0;
      wr_count_q   <= 32'd0;
      rd_addr_q    <= 6'd0;
      rd_pending_q <= 32'd0;
      rd_idx_q     <= 32'd0;
      latency_q    <= 1'b0;
      o_q          <= 16'h0000;
      busy_q       <= 1'b0;
      regs_q       <= '{default: 16'h0000};
    end else begin
      state_q      <= state_d;
      aa99_seen_q  <= aa99_seen_d;
      t2_phase_q   <= t2_phase_d;
      t2_msw_q     <= t2_msw_d;
      last_op_q    <= last_op_d;
      last_addr_q  <= last_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_count_q   <= wr_count_d;
      rd_addr_q    <= rd_addr_d;
      rd_pending_q <= rd_pending_d;
      rd_idx_q     <= rd_idx_d;
      latency_q    <= latency_d;
      o_q          <= o_d;
      busy_q       <= busy_d;
      regs_q       <= regs_d;
    end
  end

endmodule

// File: tb/tb_icap_spartan6_model.sv
// Self-checking bench for icap_spartan6_model: vector tables per scenario, expected
// readback queued as each edge is driven and compared once the edge has happened.
module tb_icap_spartan6_model;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  icap_spartan6_model_if bus ();

  icap_spartan6_model dut (
    .CLK  (CLK),
    .RST  (RST),
    .icap (bus)
  );

  // 100 MHz-style free-running clock.
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ce_n;
    logic        wr_n;
    logic [15:0] word;
    logic        chk;
    logic        busy;
    logic [15:0] o_log;
  } vec_t;

  typedef struct {
    logic        busy;
    logic [15:0] o_pin;
    int          idx;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  int    n_vectors = 0;
  int    n_miscompares = 0;
  string tag = "init";

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  function automatic logic [15:0] to_pin(input logic [15:0] l);
    return {rev8(l[15:8]), rev8(l[7:0])};
  endfunction

  function automatic void add(input logic ce_n, input logic wr_n, input logic [15:0] word,
                              input logic chk, input logic busy, input logic [15:0] o_log);
    vec_t v;
    v.ce_n = ce_n; v.wr_n = wr_n; v.word = word;
    v.chk = chk; v.busy = busy; v.o_log = o_log;
    vecs.push_back(v);
  endfunction

  function automatic void w(input logic [15:0] word);
    add(1'b0, 1'b0, word, 1'b0, 1'b0, 16'h0000);
  endfunction

  function automatic void rd(input logic busy, input logic [15:0] o_log);
    add(1'b0, 1'b1, 16'h0000, 1'b1, busy, o_log);
  endfunction

  function automatic void sync_seq();
    for (int k = 0; k < 6; k++) w(16'hFFFF);
    w(16'hAA99);
    w(16'h5566);
  endfunction

  // Drive one edge's inputs, queue its expectation, and check after the edge.
  task automatic apply_stimulus(input vec_t v, input int idx);
    exp_t e;
    bus.CE    = v.ce_n;
    bus.WRITE = v.wr_n;
    bus.I     = to_pin(v.word);
    if (v.chk) begin
      e.busy  = v.busy;
      e.o_pin = to_pin(v.o_log);
      e.idx   = idx;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    if (v.chk) check_output();
  endtask

  // Pop the oldest expectation and compare against the DUT pins.
  task automatic check_output();
    exp_t e;
    n_vectors++;
    if (sb.size() == 0) begin
      n_miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, got O=%h BUSY=%b", tag, bus.O, bus.BUSY);
    end else begin
      e = sb.pop_front();
      if (bus.O !== e.o_pin || bus.BUSY !== e.busy) begin
        n_miscompares++;
        $display("[TB] FAIL %s[%0d]: got O=%h BUSY=%b, want O=%h BUSY=%b",
                 tag, e.idx, bus.O, bus.BUSY, e.o_pin, e.busy);
      end
    end
  endtask

  // Immediate comparison outside the vector tables (reset behaviour).
  task automatic compare_now(input string name, input logic busy, input logic [15:0] o_log);
    n_vectors++;
    if (bus.O !== to_pin(o_log) || bus.BUSY !== busy) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got O=%h BUSY=%b, want O=%h BUSY=%b",
               name, bus.O, bus.BUSY, to_pin(o_log), busy);
    end
  endtask

  task automatic run_table();
    foreach (vecs[k]) apply_stimulus(vecs[k], k);
    vecs.delete();
  endtask

  task automatic do_reset();
    bus.CE    = 1'b1;
    bus.WRITE = 1'b1;
    bus.I     = 16'h0000;
    RST       = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    bus.CE    = 1'b1;
    bus.WRITE = 1'b1;
    bus.I     = 16'h0000;

    do_reset();
    #1;
    compare_now("reset_state", 1'b0, 16'h0000);
    repeat (3) @(posedge CLK);
    #1;
    compare_now("reset_hold", 1'b0, 16'h0000);

    tag = "idcode1";
    sync_seq();
    w(16'h2000); w(16'h2000); w(16'h29C1);
    add(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000);
    rd(1'b1, 16'h0000);
    rd(1'b0, 16'h2400);
    rd(1'b0, 16'h2400);
    rd(1'b0, 16'h2400);
    rd(1'b0, 16'h2400);
    run_table();

    do_reset();
    tag = "idcode2";
    sync_seq();
    w(16'h2000); w(16'h2000); w(16'h29C2);
    add(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000);
    rd(1'b1, 16'h0000);
    rd(1'b0, 16'h2400);
    w(16'h2000);
    rd(1'b0, 16'h1093);
    rd(1'b0, 16'h1093);
    rd(1'b0, 16'h1093);
    run_table();

    do_reset();
    tag = "nosync";
    w(16'h29C1);
    rd(1'b0, 16'h0000);
    rd(1'b0, 16'h0000);
    rd(1'b0, 16'h0000);
    run_table();

    do_reset();
    tag = "sync_gap";
    for (int k = 0; k < 6; k++) w(16'hFFFF);
    w(16'hAA99);
    add(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000);
    rd(1'b0, 16'h0000);
    w(16'h5566);
    w(16'h29C1);
    rd(1'b1, 16'h0000);
    rd(1'b0, 16'h2400);
    run_table();

    do_reset();
    tag = "regfile";
    sync_seq();
    w(16'h3141); w(16'h1234);
    w(16'h2941);
    rd(1'b1, 16'h0000);
    rd(1'b0, 16'h1234);
    rd(1'b0, 16'h1234);
    w(16'h2C01);
    rd(1'b1, 16'h1234);
    rd(1'b0, 16'h0000);
    w(16'h3140); w(16'h4000); w(16'h0000); w(16'h0002);
    w(16'h0001); w(16'h0BEE);
    w(16'h3061); w(16'h5A5A);
    w(16'h2941);
    rd(1'b1, 16'h0000);
    rd(1'b0, 16'h0BEE);
    w(16'h2861);
    rd(1'b1, 16'h0BEE);
    rd(1'b0, 16'h0000);
    w(16'h30A1); w(16'h000D);
    w(16'h29C1);
    rd(1'b0, 16'h0000);
    rd(1'b0, 16'h0000);
    run_table();

    do_reset();
    tag = "rst_mid";
    sync_seq();
    w(16'h29C2);
    rd(1'b1, 16'h0000);
    rd(1'b0, 16'h2400);
    w(16'h29C1);
    rd(1'b1, 16'h2400);
    run_table();
    #2;
    RST = 1'b1;
    #1;
    compare_now("rst_async", 1'b0, 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    tag = "after_rst";
    rd(1'b0, 16'h0000);
    rd(1'b0, 16'h0000);
    w(16'h29C1);
    rd(1'b0, 16'h0000);
    sync_seq();
    w(16'h2941);
    rd(1'b1, 16'h0000);
    rd(1'b0, 16'h0000);
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got 0 want 1");
    n_miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
